// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the register-file write-port arbiter.
package regfile_pkg;
    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;
    localparam int REG_ZERO   = 0;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_ARB   = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter: a lone valid wins; ties go to the requester
// not granted last (ptr_i = last grant), or always to req1 when FIXED_PRIORITY=1.
module rr_arbiter2 #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic ptr_i,
    output logic gnt0_o,
    output logic gnt1_o
);
    logic tie_pick1;

    generate
        if (FIXED_PRIORITY != 0) begin : g_fixed
            assign tie_pick1 = 1'b1;
        end else begin : g_rr
            assign tie_pick1 = ~ptr_i;
        end
    endgenerate

    assign gnt1_o = valid1_i & (~valid0_i | tie_pick1);
    assign gnt0_o = valid0_i & (~valid1_i | ~tie_pick1);
endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-sweep after reset, then arbitrates
// ALU (req0) and load (req1) writebacks. REGARB_SCOREBOARD_EN adds a busy scoreboard.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH     = REG_DATA_W,
    parameter int ADDR_WIDTH     = REG_ADDR_W,
    parameter int NUM_REGS       = REG_COUNT,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  reg_write,
    output logic [ADDR_WIDTH-1:0] write_register,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  clearing,
`ifdef REGARB_SCOREBOARD_EN
    input  logic                  sb_set_valid,
    input  logic [ADDR_WIDTH-1:0] sb_set_addr,
    output logic [NUM_REGS-1:0]   busy,
`endif
    output logic                  grant_id
);
    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  rr_q, rr_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  gid_q, gid_d;

    logic                  in_arb, gnt0, gnt1, xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_arbiter2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_arb (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .ptr_i    (rr_q),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1)
    );

    assign in_arb     = (state_q == ST_ARB);
    assign req0_ready = in_arb & gnt0;
    assign req1_ready = in_arb & gnt1;
    assign xfer       = req0_ready | req1_ready;
    assign sel_addr   = gnt1 ? req1_addr : req0_addr;
    assign sel_data   = gnt1 ? req1_data : req0_data;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        wr_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        if (state_q == ST_CLEAR) begin
            wr_d    = 1'b1;
            wreg_d  = idx_q;
            wdata_d = '0;
            gid_d   = 1'b0;
            idx_d   = idx_q + 1'b1;
            if (idx_q == ADDR_WIDTH'(NUM_REGS - 1)) state_d = ST_ARB;
        end else if (xfer) begin
            rr_d = gnt1;
            // $zero writes are accepted but never reach the register file
            if (sel_addr != ADDR_WIDTH'(REG_ZERO)) begin
                wr_d    = 1'b1;
                wreg_d  = sel_addr;
                wdata_d = sel_data;
                gid_d   = gnt1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            rr_q    <= 1'b0;
            wr_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            gid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
        end
    end

    assign reg_write      = wr_q;
    assign write_register = wreg_q;
    assign write_data     = wdata_q;
    assign grant_id       = gid_q;
    assign clearing       = (state_q == ST_CLEAR);

`ifdef REGARB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // clear first so a same-cycle set on the same register wins
    always_comb begin
        busy_d = busy_q;
        if (in_arb && xfer && sel_addr != ADDR_WIDTH'(REG_ZERO) && int'(sel_addr) < NUM_REGS)
            busy_d[sel_addr] = 1'b0;
        if (!clearing && sb_set_valid && sb_set_addr != ADDR_WIDTH'(REG_ZERO)
            && int'(sb_set_addr) < NUM_REGS)
            busy_d[sb_set_addr] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    assign busy = busy_q;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: sweep, single write, round-robin,
// $zero drop, mid-sweep reset, and (with REGARB_SCOREBOARD_EN) the busy scoreboard.
module tb_regfile_write_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        reg_write, clearing, grant_id;
    logic [4:0]  write_register;
    logic [31:0] write_data;
`ifdef REGARB_SCOREBOARD_EN
    logic        sb_set_valid;
    logic [4:0]  sb_set_addr;
    logic [31:0] busy;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_write_arbiter dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .clearing       (clearing),
`ifdef REGARB_SCOREBOARD_EN
        .sb_set_valid   (sb_set_valid),
        .sb_set_addr    (sb_set_addr),
        .busy           (busy),
`endif
        .grant_id       (grant_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full post-reset sweep; call mid-cycle right after reset_n rises
    task automatic sweep_check();
        chk("pre_sweep_clearing", 64'(clearing), 64'd1);
        chk("pre_sweep_wr", 64'(reg_write), 64'd0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("sweep_wr", 64'(reg_write), 64'd1);
            chk("sweep_idx", 64'(write_register), 64'(k - 1));
            chk("sweep_data", 64'(write_data), 64'd0);
            chk("sweep_clearing", 64'(clearing), (k < 32) ? 64'd1 : 64'd0);
            if (k == 5) begin
                req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
                #1;
                chk("sweep_ready0", 64'(req0_ready), 64'd0);
                req0_valid = 1'b0;
            end
        end
        tick();
        chk("post_sweep_clearing", 64'(clearing), 64'd0);
        chk("post_sweep_wr", 64'(reg_write), 64'd0);
    endtask

    initial begin
        logic e;
        int n0, n1;
        reset_n = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
`ifdef REGARB_SCOREBOARD_EN
        sb_set_valid = 1'b0; sb_set_addr = '0;
`endif
        tick(); tick();
        req0_valid = 1'b1; #1;
        chk("rst_wr", 64'(reg_write), 64'd0);
        chk("rst_reg", 64'(write_register), 64'd0);
        chk("rst_data", 64'(write_data), 64'd0);
        chk("rst_clearing", 64'(clearing), 64'd1);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        req0_valid = 1'b0;

        // 1: post-reset sweep
        reset_n = 1'b1;
        sweep_check();

        // 2: single ALU write
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF; #1;
        chk("t2_ready0", 64'(req0_ready), 64'd1);
        chk("t2_ready1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0;
        chk("t2_wr", 64'(reg_write), 64'd1);
        chk("t2_reg", 64'(write_register), 64'd5);
        chk("t2_data", 64'(write_data), 64'hDEADBEEF);
        chk("t2_gid", 64'(grant_id), 64'd0);
        tick();
        chk("t2_idle_wr", 64'(reg_write), 64'd0);
        chk("t2_hold_reg", 64'(write_register), 64'd5);

        // 3: both valid continuously, grants alternate starting with req1
        n0 = 0; n1 = 0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA000_0000;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hB000_0000;
        for (int j = 0; j < 4; j++) begin
            e = (j % 2 == 0);
            #1;
            chk("t3_ready0", 64'(req0_ready), 64'(!e));
            chk("t3_ready1", 64'(req1_ready), 64'(e));
            tick();
            chk("t3_wr", 64'(reg_write), 64'd1);
            chk("t3_gid", 64'(grant_id), 64'(e));
            chk("t3_reg", 64'(write_register), e ? 64'd4 : 64'd3);
            chk("t3_data", 64'(write_data),
                e ? 64'(32'hB000_0000 + n1) : 64'(32'hA000_0000 + n0));
            if (e) begin n1++; req1_data = 32'hB000_0000 + n1; end
            else   begin n0++; req0_data = 32'hA000_0000 + n0; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("t3_idle_wr", 64'(reg_write), 64'd0);

        // 4: $zero write accepted but dropped; pointer still moves
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234; #1;
        chk("t4_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        chk("t4_wr", 64'(reg_write), 64'd0);
        chk("t4_hold_reg", 64'(write_register), 64'd3);
        chk("t4_hold_data", 64'(write_data), 64'hA000_0001);
        req0_valid = 1'b1; req0_addr = 5'd6; req1_valid = 1'b1; req1_addr = 5'd7; #1;
        chk("t4_tie_ready0", 64'(req0_ready), 64'd1);
        chk("t4_tie_ready1", 64'(req1_ready), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // 5: reset mid-sweep restarts the sweep at index 0
        reset_n = 1'b0; #1;
        reset_n = 1'b1;
        for (int k = 0; k < 11; k++) tick();
        chk("t5_pre_idx", 64'(write_register), 64'd10);
        #2; reset_n = 1'b0; #1;
        chk("t5_rst_wr", 64'(reg_write), 64'd0);
        chk("t5_rst_reg", 64'(write_register), 64'd0);
        chk("t5_rst_clearing", 64'(clearing), 64'd1);
        tick();
        reset_n = 1'b1;
        sweep_check();

`ifdef REGARB_SCOREBOARD_EN
        // 6: scoreboard set/clear and set-wins
        sb_set_valid = 1'b1; sb_set_addr = 5'd7;
        tick();
        sb_set_valid = 1'b0;
        chk("t6_busy_set", 64'(busy[7]), 64'd1);
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        tick();
        req0_valid = 1'b0;
        chk("t6_wr", 64'(reg_write), 64'd1);
        chk("t6_busy_clr", 64'(busy[7]), 64'd0);
        sb_set_valid = 1'b1; sb_set_addr = 5'd7;
        req0_valid = 1'b1;
        tick();
        sb_set_valid = 1'b0; req0_valid = 1'b0;
        chk("t6_busy_setwins", 64'(busy[7]), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
